memctl: RTL
===========

MEMCTL -- requirements
Module: memctl

Interface
REQ-001 SHALL have parameter TEXT_HI, default 4'hF, upper address nibble of the 4 KB text window (0xF000-0xFFFF).
REQ-002 SHALL have parameter IO_LO, default 16'h0020, first I/O address; the I/O range is IO_LO..IO_LO+0x3F.
REQ-003 SHALL have port clock, input, 1, the single system clock for all state.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cpu_address, input, 16, CPU data-space address.
REQ-006 SHALL have port cpu_data_o, input, 8, CPU write data.
REQ-007 SHALL have port cpu_wren, input, 1, CPU write strobe for the current cycle.
REQ-008 SHALL have port cpu_data_i, output, 8, read data returned to the CPU.
REQ-009 SHALL have port sram_q, input, 8, SRAM read data, valid one clock after the address.
REQ-010 SHALL have port sram_we, output, 1, SRAM write enable (SRAM address is cpu_address directly).
REQ-011 SHALL have port text_q, input, 8, text-memory port-A read data, valid one clock after the address.
REQ-012 SHALL have port text_address, output, 13, text-memory port-A address.
REQ-013 SHALL have port text_data, output, 8, text-memory port-A write data.
REQ-014 SHALL have port text_we, output, 1, text-memory port-A write enable.
REQ-015 SHALL have port bank, output, 8, BANK register value.
REQ-016 SHALL have port fill_busy, output, 1, high while the fill engine is active.
REQ-017 SHALL have port fill_done, output, 1, one-clock pulse at fill completion.

Function
REQ-018 SHALL decode each cycle: TEXT if cpu_address[15:12]==TEXT_HI; IO if in the I/O range; else SRAM.
REQ-019 SHALL drive sram_we = cpu_wren & SRAM-hit; I/O and TEXT writes never reach SRAM.
REQ-020 SHALL implement I/O registers: IO_LO+0 BANK[7:0]; IO_LO+1 CTRL (bit0 plane, bit7 start/busy); IO_LO+2 FILLVAL[7:0].
REQ-021 SHALL ignore writes to unimplemented I/O addresses, which read 0x00.
REQ-022 SHALL register the decoded read source (NONE/SRAM/TEXT/IO) and, for IO, the register value, on every clock; cpu_data_i is muxed from that registered source, giving exactly 1-cycle read latency for all regions.
REQ-023 CTRL read SHALL return {fill_busy, 6'b0, plane}.
REQ-024 CPU TEXT access SHALL set text_address={plane, cpu_address[11:0]}, text_data=cpu_data_o, text_we=cpu_wren.
REQ-025 Fill FSM states SHALL be IDLE, FILL and DONE.
REQ-026 IDLE->FILL SHALL occur on a CPU write to CTRL with bit7=1; on that edge SHALL latch fill_plane=written bit0, fill_value=FILLVAL, ptr=0.
REQ-027 In FILL, text port SHALL go to the CPU whenever the CPU hits TEXT (CPU priority); otherwise text_address={fill_plane, ptr}, text_data=fill_value, text_we=1, and ptr increments.
REQ-028 A stalled cycle SHALL NOT advance ptr; no address is skipped or written twice.
REQ-029 FILL->DONE SHALL occur on the clock the write with ptr==4095 completes; DONE lasts one clock with fill_done=1, then IDLE.
REQ-030 fill_busy SHALL be 1 in FILL and DONE.
REQ-031 While busy, CTRL and FILLVAL writes SHALL be ignored entirely; BANK writes SHALL still take effect.
REQ-032 A CTRL write with bit7=0 in IDLE SHALL only update plane.
REQ-033 ptr SHALL be 12 bits and SHALL NOT wrap past 4095 (FSM exits at 4095).
REQ-034 Fill of 4096 bytes with no CPU contention SHALL take exactly 4096 FILL cycles.

Reset
REQ-035 While reset=1, SHALL force sram_we=0 and text_we=0, and SHALL load BANK=0x00, plane=0, FILLVAL=0x00, state=IDLE, ptr=0, fill_done=0, and read source=NONE (cpu_data_i=0x00 the following cycle).
REQ-036 Reset asserted mid-fill SHALL abort the fill without a fill_done pulse; already-written bytes remain.

Verification
REQ-037 Write 0x5A to 0x0100, read 0x0100 -> sram_we=1 on write cycle only; cpu_data_i=sram_q one clock after read address.
REQ-038 Write 0x07 to BANK (0x0020), read back -> bank=0x07 next clock; cpu_data_i=0x07 one clock after read; sram_we stays 0.
REQ-039 Set CTRL plane=1, write 0x41 to 0xF123 -> text_address=0x1123, text_data=0x41, text_we=1.
REQ-040 FILLVAL=0x20, CTRL=0x80, no CPU traffic -> 4096 writes at 0x0000..0x0FFF with data 0x20, then fill_done one clock, fill_busy falls, total 4097 busy clocks.
REQ-041 During a fill, CPU reads 0xF010 on 3 cycles -> those cycles carry the CPU address with text_we=0; ptr holds; the fill still covers all 4096 addresses exactly once and ends 3 clocks later.
REQ-042 Reset at ptr=100 -> next clock fill_busy=0, no fill_done; CTRL read returns 0x00; a new start restarts at ptr=0.

Source files
------------

// File: rtl/memctl.sv
// Memory controller: address decode for SRAM / text window / I/O registers,
// 1-cycle registered read mux, and a background text-plane fill engine.
module memctl #(
  parameter logic [3:0]  TEXT_HI = 4'hF,
  parameter logic [15:0] IO_LO   = 16'h0020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_o,
  input  logic        cpu_wren,
  output logic [7:0]  cpu_data_i,
  input  logic [7:0]  sram_q,
  output logic        sram_we,
  input  logic [7:0]  text_q,
  output logic [12:0] text_address,
  output logic [7:0]  text_data,
  output logic        text_we,
  output logic [7:0]  bank,
  output logic        fill_busy,
  output logic        fill_done
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_SRAM, SRC_TEXT, SRC_IO} src_t;

  localparam logic [15:0] IO_HI = IO_LO + 16'h003F;

  state_t      state;
  src_t        rd_src;
  logic [7:0]  rd_io, io_rd_val, fillval, fill_value;
  logic [11:0] ptr;
  logic        plane, fill_plane;
  logic        text_hit, io_hit, sram_hit;
  logic        bank_wr, ctrl_wr, fillval_wr;
  logic [15:0] io_off;

  assign text_hit   = cpu_address[15:12] == TEXT_HI;
  assign io_hit     = !text_hit && (cpu_address >= IO_LO) && (cpu_address <= IO_HI);
  assign sram_hit   = !text_hit && !io_hit;
  assign io_off     = cpu_address - IO_LO;
  assign bank_wr    = cpu_wren && io_hit && (io_off == 16'd0);
  assign ctrl_wr    = cpu_wren && io_hit && (io_off == 16'd1);
  assign fillval_wr = cpu_wren && io_hit && (io_off == 16'd2);

  assign sram_we = cpu_wren && sram_hit && !reset;

  always_comb begin
    io_rd_val = 8'h00;
    if (io_hit) begin
      case (io_off)
        16'd0:   io_rd_val = bank;
        16'd1:   io_rd_val = {fill_busy, 6'b0, plane};
        16'd2:   io_rd_val = fillval;
        default: io_rd_val = 8'h00;
      endcase
    end
  end

  // CPU owns the text port whenever it hits the window; the fill only gets leftover cycles.
  always_comb begin
    text_address = {plane, cpu_address[11:0]};
    text_data    = cpu_data_o;
    text_we      = 1'b0;
    if (reset) begin
      text_we = 1'b0;
    end else if (text_hit) begin
      text_we = cpu_wren;
    end else if (state == FILL) begin
      text_address = {fill_plane, ptr};
      text_data    = fill_value;
      text_we      = 1'b1;
    end
  end

  always_comb begin
    case (rd_src)
      SRC_SRAM: cpu_data_i = sram_q;
      SRC_TEXT: cpu_data_i = text_q;
      SRC_IO:   cpu_data_i = rd_io;
      default:  cpu_data_i = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_src     <= SRC_NONE;
      rd_io      <= 8'h00;
      bank       <= 8'h00;
      plane      <= 1'b0;
      fillval    <= 8'h00;
      ptr        <= 12'd0;
      fill_plane <= 1'b0;
      fill_value <= 8'h00;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      rd_src    <= text_hit ? SRC_TEXT : (io_hit ? SRC_IO : SRC_SRAM);
      rd_io     <= io_rd_val;
      fill_done <= 1'b0;
      if (bank_wr) bank <= cpu_data_o;
      case (state)
        IDLE: begin
          if (ctrl_wr) begin
            plane <= cpu_data_o[0];
            if (cpu_data_o[7]) begin
              state      <= FILL;
              fill_busy  <= 1'b1;
              fill_plane <= cpu_data_o[0];
              fill_value <= fillval;
              ptr        <= 12'd0;
            end
          end else if (fillval_wr) begin
            fillval <= cpu_data_o;
          end
        end
        FILL: begin
          // A CPU text hit stalls the engine; ptr only moves on a real write.
          if (!text_hit) begin
            if (ptr == 12'hFFF) begin
              state     <= DONE;
              fill_done <= 1'b1;
            end else begin
              ptr <= ptr + 12'd1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
